// File: rtl/camera_frame_crop.sv
// Camera frame crop: frame enable, frame dropping, window slicing and little-endian 32-bit packing
// in front of the uDMA RX channel. Define CAM_FRAME_FLUSH_EN to zero-pad and push partial words at frame end.
module camera_frame_crop #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned COORD_W    = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cfg_en_i,
  input  logic               cfg_frame_drop_en_i,
  input  logic [5:0]         cfg_frame_drop_cnt_i,
  input  logic               cfg_slice_en_i,
  input  logic [COORD_W-1:0] cfg_ll_x_i,
  input  logic [COORD_W-1:0] cfg_ll_y_i,
  input  logic [COORD_W-1:0] cfg_ur_x_i,
  input  logic [COORD_W-1:0] cfg_ur_y_i,
  input  logic [COORD_W-1:0] cfg_row_len_i,
  input  logic               clr_i,
  input  logic               pix_sof_i,
  input  logic               pix_valid_i,
  input  logic [7:0]         pix_data_i,
  output logic [31:0]        data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               ip_en_o,
  output logic               frame_done_o,
  output logic               overflow_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_ACTIVE, ST_DROP} state_e;

  state_e             state_q, state_d;
  logic [5:0]         drop_cnt_q, drop_cnt_d;
  logic               frame_done_q;
  logic               frame_end;
  logic               capture;
  logic               in_win;
  logic               keep;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [1:0]         pk_cnt_q, pk_cnt_d;
  logic [23:0]        pk_word_q, pk_word_d;
  logic               push;
  logic [31:0]        push_data;
  logic               pop;
  logic               push_ok;
  logic               full;
  logic               empty;
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic [31:0]        mem [FIFO_DEPTH];
  logic               overflow_q;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (pix_sof_i) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (pix_sof_i && cfg_frame_drop_en_i && (cfg_frame_drop_cnt_i != 6'd0)) begin
            state_d    = ST_DROP;
            drop_cnt_d = cfg_frame_drop_cnt_i;
          end
        end
        ST_DROP: begin
          // A count cleared by clr_i while dropping resumes capture rather than stalling.
          if (pix_sof_i) begin
            if (drop_cnt_q <= 6'd1) state_d = ST_ACTIVE;
            drop_cnt_d = (drop_cnt_q == 6'd0) ? 6'd0 : drop_cnt_q - 6'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clr_i) drop_cnt_d = 6'd0;
  end

  assign frame_end = (state_q == ST_ACTIVE) && (pix_sof_i || !cfg_en_i);
  // A byte arriving with SOF belongs to the new frame, so it follows the post-SOF state.
  assign capture   = cfg_en_i && (pix_sof_i ? (state_d == ST_ACTIVE) : (state_q == ST_ACTIVE));

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      drop_cnt_q   <= 6'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_done_q <= frame_end;
    end
  end

  assign ip_en_o      = (state_q == ST_ACTIVE) || (state_q == ST_DROP);
  assign frame_done_o = frame_done_q;

  assign cur_x  = pix_sof_i ? '0 : x_q;
  assign cur_y  = pix_sof_i ? '0 : y_q;
  assign in_win = (cur_x >= cfg_ll_x_i) && (cur_x <= cfg_ur_x_i) &&
                  (cur_y >= cfg_ll_y_i) && (cur_y <= cfg_ur_y_i);
  assign keep   = pix_valid_i && capture && (!cfg_slice_en_i || in_win);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_valid_i) begin
      if (cur_x == cfg_row_len_i) begin
        x_q <= '0;
        y_q <= (&cur_y) ? cur_y : cur_y + 1'b1;
      end else begin
        x_q <= cur_x + 1'b1;
        y_q <= cur_y;
      end
    end else if (pix_sof_i) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

  // Unused upper packer bytes are always zero, which doubles as the flush padding.
  always_comb begin
    pk_cnt_d  = pk_cnt_q;
    pk_word_d = pk_word_q;
    push      = 1'b0;
    push_data = '0;
    if (frame_end || !cfg_en_i) begin
`ifdef CAM_FRAME_FLUSH_EN
      if (frame_end && (pk_cnt_q != 2'd0)) begin
        push      = 1'b1;
        push_data = {8'h00, pk_word_q};
      end
`endif
      pk_cnt_d  = 2'd0;
      pk_word_d = '0;
    end
    if (keep) begin
      if (pk_cnt_d == 2'd3) begin
        push      = 1'b1;
        push_data = {pix_data_i, pk_word_d};
        pk_cnt_d  = 2'd0;
        pk_word_d = '0;
      end else begin
        case (pk_cnt_d)
          2'd0:    pk_word_d[7:0]   = pix_data_i;
          2'd1:    pk_word_d[15:8]  = pix_data_i;
          default: pk_word_d[23:16] = pix_data_i;
        endcase
        pk_cnt_d = pk_cnt_d + 2'd1;
      end
    end
    if (clr_i) begin
      push      = 1'b0;
      pk_cnt_d  = 2'd0;
      pk_word_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pk_cnt_q  <= 2'd0;
      pk_word_q <= '0;
    end else begin
      pk_cnt_q  <= pk_cnt_d;
      pk_word_q <= pk_word_d;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !empty && ready_i;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; only the pointers are, and data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_camera_frame_crop.sv
// Self-checking bench for camera_frame_crop: directed scenarios plus randomized frames
// compared against a frame/coordinate-level reference model.
module tb_camera_frame_crop;

  localparam int FIFO_DEPTH = 2;
  localparam int COORD_W    = 16;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic               cfg_en_i = 1'b0;
  logic               cfg_frame_drop_en_i = 1'b0;
  logic [5:0]         cfg_frame_drop_cnt_i = '0;
  logic               cfg_slice_en_i = 1'b0;
  logic [COORD_W-1:0] cfg_ll_x_i = '0;
  logic [COORD_W-1:0] cfg_ll_y_i = '0;
  logic [COORD_W-1:0] cfg_ur_x_i = '0;
  logic [COORD_W-1:0] cfg_ur_y_i = '0;
  logic [COORD_W-1:0] cfg_row_len_i = 16'd3;
  logic               clr_i = 1'b0;
  logic               pix_sof_i = 1'b0;
  logic               pix_valid_i = 1'b0;
  logic [7:0]         pix_data_i = '0;
  logic [31:0]        data_o;
  logic               valid_o;
  logic               ready_i = 1'b0;
  logic               ip_en_o;
  logic               frame_done_o;
  logic               overflow_o;

  always #5 clk_i = ~clk_i;

  camera_frame_crop #(.FIFO_DEPTH(FIFO_DEPTH), .COORD_W(COORD_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i),
    .cfg_frame_drop_en_i(cfg_frame_drop_en_i), .cfg_frame_drop_cnt_i(cfg_frame_drop_cnt_i),
    .cfg_slice_en_i(cfg_slice_en_i), .cfg_ll_x_i(cfg_ll_x_i), .cfg_ll_y_i(cfg_ll_y_i),
    .cfg_ur_x_i(cfg_ur_x_i), .cfg_ur_y_i(cfg_ur_y_i), .cfg_row_len_i(cfg_row_len_i),
    .clr_i(clr_i), .pix_sof_i(pix_sof_i), .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .ip_en_o(ip_en_o),
    .frame_done_o(frame_done_o), .overflow_o(overflow_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  part_q[$];
  int          frame_idx = 0;
  int          byte_idx  = 0;
  bit          cur_capt  = 1'b0;
  bit          hold_mode = 1'b0;
  bit          exp_ovf   = 1'b0;
  int          exp_done  = 0;
  int          got_done  = 0;
  int          zero_run  = 0;

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (frame_done_o) got_done++;
      if (valid_o && ready_i && !clr_i) begin
        got_q.push_back(data_o);
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word_data", data_o, exp_q.pop_front());
      end
    end
  end

  task automatic model_push_word(input logic [31:0] w);
    if (hold_mode && exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic model_frame_end();
    if (cur_capt) begin
      exp_done++;
`ifdef CAM_FRAME_FLUSH_EN
      if (part_q.size() != 0) begin
        logic [31:0] w;
        w = '0;
        foreach (part_q[i]) w[8*i +: 8] = part_q[i];
        model_push_word(w);
      end
`endif
    end
    part_q.delete();
    cur_capt = 1'b0;
  endtask

  // Frame k after enable is captured when k is a multiple of (drop_cnt + 1).
  task automatic model_sof();
    int n;
    model_frame_end();
    n = int'(cfg_frame_drop_cnt_i);
    cur_capt = (!cfg_frame_drop_en_i || n == 0) ? 1'b1 : ((frame_idx % (n + 1)) == 0);
    frame_idx++;
    byte_idx = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int x, y, row;
    row = int'(cfg_row_len_i) + 1;
    x = byte_idx % row;
    y = byte_idx / row;
    byte_idx++;
    if (cur_capt && (!cfg_slice_en_i ||
        (x >= int'(cfg_ll_x_i) && x <= int'(cfg_ur_x_i) &&
         y >= int'(cfg_ll_y_i) && y <= int'(cfg_ur_y_i)))) begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        model_push_word({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
      end
    end
  endtask

  task automatic cyc(input bit sof, input bit v, input logic [7:0] d);
    pix_sof_i   = sof;
    pix_valid_i = v;
    pix_data_i  = d;
    if (hold_mode)          ready_i = 1'b0;
    else if (zero_run >= 2) ready_i = 1'b1;
    else                    ready_i = ($urandom_range(3) != 0);
    zero_run = ready_i ? 0 : zero_run + 1;
    @(posedge clk_i);
    #1;
    pix_sof_i   = 1'b0;
    pix_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit rnd, input bit sof_byte, input logic [7:0] base);
    logic [7:0] b;
    model_sof();
    if (!sof_byte || n == 0) cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : base + 8'(i);
      if (i == 0 && sof_byte) begin
        model_byte(b);
        cyc(1'b1, 1'b1, b);
      end else begin
        while ($urandom_range(3) == 0) cyc(1'b0, 1'b0, 8'($urandom));
        model_byte(b);
        cyc(1'b0, 1'b1, b);
      end
    end
  endtask

  task automatic enable_cap();
    cfg_en_i  = 1'b1;
    frame_idx = 0;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic disable_cap();
    model_frame_end();
    cfg_en_i = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid_o) && t < 200) begin
      cyc(1'b0, 1'b0, 8'h00);
      t++;
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cnt"}, 32'(got_done), 32'(exp_done));
    check({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_data", data_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ip_en", 32'(ip_en_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    check("post_rst_valid", 32'(valid_o), 32'd0);

    // Basic capture
    enable_cap();
    check("wait_sof_ip_en", 32'(ip_en_o), 32'd0);
    got_q.delete();
    send_frame(8, 1'b0, 1'b0, 8'h01);
    check("basic_ip_en", 32'(ip_en_o), 32'd1);
    model_sof();
    cyc(1'b1, 1'b0, 8'h00);
    check("basic_done_pulse", 32'(frame_done_o), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check("basic_done_low", 32'(frame_done_o), 32'd0);
    disable_cap();
    drain("basic");
    check("basic_nwords", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("basic_w0", got_q[0], 32'h04030201);
      check("basic_w1", got_q[1], 32'h08070605);
    end

    // Window slicing
    cfg_row_len_i = 16'd7; cfg_slice_en_i = 1'b1;
    cfg_ll_x_i = 16'd2; cfg_ll_y_i = 16'd1; cfg_ur_x_i = 16'd5; cfg_ur_y_i = 16'd2;
    enable_cap();
    got_q.delete();
    send_frame(32, 1'b0, 1'b0, 8'h00);
    disable_cap();
    drain("slice");
    check("slice_nwords", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("slice_w0", got_q[0], 32'h0D0C0B0A);
      check("slice_w1", got_q[1], 32'h15141312);
    end

    // Frame drop
    cfg_slice_en_i = 1'b0; cfg_row_len_i = 16'd3;
    cfg_frame_drop_en_i = 1'b1; cfg_frame_drop_cnt_i = 6'd2;
    enable_cap();
    got_q.delete();
    for (int f = 0; f < 5; f++) send_frame(4, 1'b0, 1'b0, 8'(16 * f + 1));
    check("drop_ip_en", 32'(ip_en_o), 32'd1);
    disable_cap();
    drain("drop");
    check("drop_nwords", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("drop_w0", got_q[0], 32'h04030201);
      check("drop_w1", got_q[1], 32'h34333231);
    end

    // Backpressure, overflow and clear
    cfg_frame_drop_en_i = 1'b0;
    enable_cap();
    hold_mode = 1'b1;
    send_frame(12, 1'b0, 1'b0, 8'h41);
    check("bp_valid", 32'(valid_o), 32'd1);
    check("bp_head", data_o, 32'h44434241);
    check("bp_ovf", 32'(overflow_o), 32'(exp_ovf));
    check("bp_ovf_set", 32'(overflow_o), 32'd1);
    clr_i = 1'b1;
    exp_q.delete(); part_q.delete(); exp_ovf = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    clr_i = 1'b0;
    check("clr_valid", 32'(valid_o), 32'd0);
    check("clr_ovf", 32'(overflow_o), 32'd0);
    hold_mode = 1'b0;
    send_frame(8, 1'b1, 1'b0, 8'h00);
    disable_cap();
    drain("bp");

    // Disable mid-frame
    enable_cap();
    got_q.delete();
    send_frame(6, 1'b0, 1'b0, 8'h01);
    disable_cap();
    check("dis_done_pulse", 32'(frame_done_o), 32'd1);
    check("dis_ip_en", 32'(ip_en_o), 32'd0);
    drain("dis");
`ifdef CAM_FRAME_FLUSH_EN
    check("dis_nwords", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) check("dis_flush_word", got_q[1], 32'h00000605);
`else
    check("dis_nwords", 32'(got_q.size()), 32'd1);
`endif
    if (got_q.size() >= 1) check("dis_w0", got_q[0], 32'h04030201);

    // SOF coincident with a valid byte, from WAIT_SOF and from ACTIVE
    enable_cap();
    got_q.delete();
    send_frame(4, 1'b0, 1'b1, 8'hA0);
    send_frame(8, 1'b0, 1'b1, 8'hB0);
    disable_cap();
    drain("sofv");
    check("sofv_nwords", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 2) begin
      check("sofv_byte0", got_q[0] & 32'hFF, 32'hA0);
      check("sofv_w0", got_q[0], 32'hA3A2A1A0);
      check("sofv_w1", got_q[1], 32'hB3B2B1B0);
    end

    // Randomized configurations and frames
    for (int it = 0; it < 25; it++) begin
      cfg_row_len_i        = 16'($urandom_range(9));
      cfg_slice_en_i       = 1'($urandom);
      cfg_ll_x_i           = 16'($urandom_range(6));
      cfg_ll_y_i           = 16'($urandom_range(4));
      cfg_ur_x_i           = 16'($urandom_range(8));
      cfg_ur_y_i           = 16'($urandom_range(5));
      cfg_frame_drop_en_i  = 1'($urandom);
      cfg_frame_drop_cnt_i = 6'($urandom_range(3));
      enable_cap();
      for (int f = 0; f < int'($urandom_range(5, 1)); f++)
        send_frame(int'($urandom_range(24)), 1'b1, 1'($urandom), 8'h00);
      disable_cap();
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/camera_frame_crop.md
Name: camera_frame_crop

Overview:
- Sits between the camera pixel synchroniser and the uDMA RX channel.
- Consumes the decoded camera configuration fields (global, lower-left, upper-right, row size, frame drop).
- Applies frame enable, frame dropping and window slicing to an 8-bit pixel byte stream.
- Packs the surviving bytes little-endian into 32-bit words and presents them on a valid/ready interface to the RX channel through a small output FIFO.

Parameters:
- FIFO_DEPTH, 2, number of 32-bit entries in the output FIFO (power of two, >=2)
- COORD_W, 16, width of x/y counters and window coordinates

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  capture enable (from global cfg bit 0)
- cfg_frame_drop_en_i  in  1  frame dropping enable
- cfg_frame_drop_cnt_i  in  6  frames skipped after each captured frame
- cfg_slice_en_i  in  1  window slicing enable
- cfg_ll_x_i / cfg_ll_y_i  in  COORD_W  window lower-left corner (inclusive)
- cfg_ur_x_i / cfg_ur_y_i  in  COORD_W  window upper-right corner (inclusive)
- cfg_row_len_i  in  COORD_W  bytes per row minus 1
- clr_i  in  1  pulse: flush FIFO, clear packer and overflow flag
- pix_sof_i  in  1  start-of-frame pulse (vsync edge), 1 cycle
- pix_valid_i  in  1  pixel byte valid
- pix_data_i  in  8  pixel byte
- data_o  out  32  packed word to RX channel
- valid_o  out  1  data_o valid
- ready_i  in  1  RX channel accepts data_o
- ip_en_o  out  1  1 while in ACTIVE or DROP (read back as global cfg bit 31)
- frame_done_o  out  1  1-cycle pulse when a captured frame ends
- overflow_o  out  1  sticky: byte lost because FIFO was full

Behaviour:
- Reset values:
  - data_o = 0, valid_o = 0, ip_en_o = 0, frame_done_o = 0, overflow_o = 0.
  - FSM = IDLE, counters = 0, packer empty.
- FSM states: IDLE, WAIT_SOF, ACTIVE, DROP.
  - IDLE -> WAIT_SOF when cfg_en_i = 1.
  - WAIT_SOF -> ACTIVE on pix_sof_i.
  - ACTIVE -> DROP on pix_sof_i when cfg_frame_drop_en_i = 1 and cfg_frame_drop_cnt_i != 0. This loads drop_cnt = cfg_frame_drop_cnt_i.
  - ACTIVE -> ACTIVE on pix_sof_i otherwise (new frame captured).
  - DROP: each pix_sof_i decrements drop_cnt. On the SOF where drop_cnt == 1, go to ACTIVE; that SOF starts a captured frame.
  - Any state -> IDLE in the same cycle cfg_en_i = 0. The partial packer word is discarded; FIFO contents keep draining.
- frame_done_o pulses 1 cycle after any pix_sof_i seen in ACTIVE, and also when cfg_en_i falls in ACTIVE.
- Counters:
  - x, y reset to 0 on every pix_sof_i.
  - Each pix_valid_i cycle increments x. When x == cfg_row_len_i, x wraps to 0 and y increments.
  - y saturates at all-ones.
  - pix_sof_i and pix_valid_i in the same cycle: the byte is pixel (0,0) of the new frame.
- Window test:
  - byte kept if state == ACTIVE and (cfg_slice_en_i == 0 or (ll_x <= x <= ur_x and ll_y <= y <= ur_y)), unsigned compares.
  - ll > ur on either axis keeps nothing.
- Packer:
  - kept bytes fill a 32-bit word, byte 0 in bits [7:0].
  - Fourth byte pushes the word into the FIFO in the same cycle, 1 cycle latency to valid_o when FIFO was empty.
  - Partial word at SOF is discarded, unless the optional feature is enabled.
- FIFO:
  - push and pop in the same cycle allowed when full.
  - valid_o = !empty, data_o = head entry.
  - A push attempt while full (and no pop) drops the word and sets overflow_o.
- clr_i:
  - empties the FIFO and packer, clears overflow_o and drop_cnt.
  - FSM unchanged.
  - clr_i has priority over a simultaneous push.
- Config inputs are sampled live. Software changes them only while cfg_en_i = 0.

Optional Feature:
- Macro CAM_FRAME_FLUSH_EN.
- Defined: at end of a captured frame (SOF in ACTIVE, or cfg_en_i falling in ACTIVE), a non-empty partial word is zero-padded in upper bytes and pushed. Overflow rules are unchanged.
- Undefined: partial words at frame end are discarded, and the frame's byte count must be a multiple of 4 to be fully transferred.

Test Plan:
- Basic capture: en = 1, slice off, row_len = 3, SOF then bytes 0x01..0x08, ready = 1 -> words 0x04030201, 0x08070605; ip_en_o = 1; frame_done_o pulses at next SOF.
- Slicing: row_len = 7, ll = (2,1), ur = (5,2), 4 rows of bytes = 8*y+x -> exactly words 0x0D0C0B0A and 0x15141312.
- Frame drop: drop_en = 1, drop_cnt = 2, 5 frames of 4 bytes -> frames 1 and 4 captured, 2, 3, 5 dropped.
- Backpressure: FIFO_DEPTH = 2, ready = 0, 12 kept bytes -> 2 words held, overflow_o = 1; clr_i -> valid_o = 0, overflow_o = 0.
- Disable mid-frame: 6 bytes then cfg_en_i = 0 -> one word output, partial dropped (flush build: second word 0x0000_0605), frame_done_o pulse, ip_en_o = 0.
- SOF with coincident pix_valid_i: byte is counted at (0,0) and appears in bits [7:0] of the first word.
